// File: rtl/bft_pkt_pkg.sv
// bft_pkt_pkg: BFT packet field layout constants and packet helpers
package bft_pkt_pkg;
  localparam int BFT_PACKET_BITS   = 49;
  localparam int BFT_NUM_LEAF_BITS = 3;
  localparam int BFT_NUM_PORT_BITS = 4;
  localparam int VALID_BIT = BFT_PACKET_BITS - 1;
  localparam int LEAF_MSB  = VALID_BIT - 1;
  localparam int LEAF_LSB  = VALID_BIT - BFT_NUM_LEAF_BITS;
  localparam int PORT_MSB  = LEAF_LSB - 1;
  localparam int PORT_LSB  = LEAF_LSB - BFT_NUM_PORT_BITS;
  function automatic logic pkt_valid(input logic [BFT_PACKET_BITS-1:0] pkt);
    return pkt[VALID_BIT];
  endfunction
endpackage

// File: rtl/bft_pkt_fifo.sv
// bft_pkt_fifo: first-word-fall-through packet FIFO; ports: clk, reset (async low), i_wr_en/i_wr_data push, i_rd_en pop request, o_rd_data head, o_count/o_count_next occupancy, o_push/o_pop/o_full status
module bft_pkt_fifo #(
  parameter int WIDTH = 49,
  parameter int DEPTH = 8,
  localparam int PTR_BITS = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_wr_en,
  input  logic [WIDTH-1:0]    i_wr_data,
  input  logic                i_rd_en,
  output logic [WIDTH-1:0]    o_rd_data,
  output logic [PTR_BITS:0]   o_count,
  output logic [PTR_BITS:0]   o_count_next,
  output logic                o_push,
  output logic                o_pop,
  output logic                o_full
);
  logic [WIDTH-1:0]    r_mem [DEPTH];
  logic [PTR_BITS-1:0] r_wr_ptr, r_rd_ptr;
  logic [PTR_BITS:0]   r_count;
  logic                w_empty;
  assign w_empty      = r_count == '0;
  assign o_full       = r_count == (PTR_BITS+1)'(DEPTH);
  assign o_pop        = !w_empty && i_rd_en;
  // a pop in the same cycle frees the slot the write lands in, so full is not blocking then
  assign o_push       = i_wr_en && (!o_full || o_pop);
  assign o_count_next = r_count + (PTR_BITS+1)'(o_push) - (PTR_BITS+1)'(o_pop);
  assign o_rd_data    = w_empty ? '0 : r_mem[r_rd_ptr];
  assign o_count      = r_count;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (o_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (o_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= o_count_next;
    end
  end
  always_ff @(posedge clk) begin
    if (o_push) r_mem[r_wr_ptr] <= i_wr_data;
  end
endmodule

// File: rtl/bft_leaf_buffer.sv
// bft_leaf_buffer: leaf<->BFT buffer; ports: clk, reset (async low), i_leaf_data/o_leaf_ready egress in, o_net_data/i_net_ready egress out, i_net_data/o_leaf_data ingress, o_occupancy/o_tx_count/o_rx_count/o_overflow debug
module bft_leaf_buffer
  import bft_pkt_pkg::*;
#(
  parameter int PACKET_BITS   = BFT_PACKET_BITS,
  parameter int NUM_LEAF_BITS = BFT_NUM_LEAF_BITS,
  parameter int NUM_PORT_BITS = BFT_NUM_PORT_BITS,
  parameter int FIFO_DEPTH    = 8,
  parameter int CNT_BITS      = 16,
  localparam int PTR_BITS     = $clog2(FIFO_DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [PACKET_BITS-1:0] i_leaf_data,
  output logic                   o_leaf_ready,
  output logic [PACKET_BITS-1:0] o_leaf_data,
  input  logic [PACKET_BITS-1:0] i_net_data,
  output logic [PACKET_BITS-1:0] o_net_data,
  input  logic                   i_net_ready,
  output logic [PTR_BITS:0]      o_occupancy,
  output logic [CNT_BITS-1:0]    o_tx_count,
  output logic [CNT_BITS-1:0]    o_rx_count,
  output logic                   o_overflow
);
  if (PACKET_BITS < NUM_LEAF_BITS + NUM_PORT_BITS + 1) begin : g_bad_fields
    $error("packet too narrow for leaf and port fields");
  end
  if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two and at least 4");
  end
  logic                   w_leaf_valid, w_net_valid, w_push, w_pop, w_full;
  logic [PTR_BITS:0]      w_count_next;
  logic                   r_leaf_ready, r_overflow;
  logic [PACKET_BITS-1:0] r_leaf_data;
  logic [CNT_BITS-1:0]    r_tx_count, r_rx_count;
  assign w_leaf_valid = pkt_valid(i_leaf_data);
  assign w_net_valid  = pkt_valid(i_net_data);
  bft_pkt_fifo #(.WIDTH(PACKET_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .i_wr_en      (w_leaf_valid),
    .i_wr_data    (i_leaf_data),
    .i_rd_en      (i_net_ready),
    .o_rd_data    (o_net_data),
    .o_count      (o_occupancy),
    .o_count_next (w_count_next),
    .o_push       (w_push),
    .o_pop        (w_pop),
    .o_full       (w_full)
  );
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_leaf_ready <= 1'b0;
      r_leaf_data  <= '0;
      r_tx_count   <= '0;
      r_rx_count   <= '0;
      r_overflow   <= 1'b0;
    end else begin
      // two free slots absorb the word the leaf sends before it sees ready drop
      r_leaf_ready <= w_count_next <= (PTR_BITS+1)'(FIFO_DEPTH - 2);
      r_leaf_data  <= i_net_data;
      r_tx_count   <= r_tx_count + CNT_BITS'(w_pop);
      r_rx_count   <= r_rx_count + CNT_BITS'(w_net_valid);
      r_overflow   <= r_overflow | (w_leaf_valid & w_full & !w_push);
    end
  end
  assign o_leaf_ready = r_leaf_ready;
  assign o_leaf_data  = r_leaf_data;
  assign o_tx_count   = r_tx_count;
  assign o_rx_count   = r_rx_count;
  assign o_overflow   = r_overflow;
endmodule

// File: tb/tb_bft_leaf_buffer.sv
// tb_bft_leaf_buffer: scoreboard bench for bft_leaf_buffer with a queue-based reference model
module tb_bft_leaf_buffer;
  localparam int PB = 49;
  localparam int D  = 8;
  localparam int CB = 16;
  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [PB-1:0] i_leaf_data = '0;
  logic [PB-1:0] i_net_data = '0;
  logic          i_net_ready = 1'b0;
  logic          o_leaf_ready, o_overflow;
  logic [PB-1:0] o_leaf_data, o_net_data;
  logic [3:0]    o_occupancy;
  logic [CB-1:0] o_tx_count, o_rx_count;
  int checks = 0;
  int errors = 0;
  logic [PB-1:0] sb[$];
  int            exp_count = 0;
  logic          exp_ready = 1'b0;
  logic          exp_ovf = 1'b0;
  logic [CB-1:0] exp_tx = '0;
  logic [CB-1:0] exp_rx = '0;
  logic [PB-1:0] exp_leaf_data = '0;
  bft_leaf_buffer dut (
    .clk          (clk),
    .reset        (reset),
    .i_leaf_data  (i_leaf_data),
    .o_leaf_ready (o_leaf_ready),
    .o_leaf_data  (o_leaf_data),
    .i_net_data   (i_net_data),
    .o_net_data   (o_net_data),
    .i_net_ready  (i_net_ready),
    .o_occupancy  (o_occupancy),
    .o_tx_count   (o_tx_count),
    .o_rx_count   (o_rx_count),
    .o_overflow   (o_overflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask
  function automatic logic [PB-1:0] pkt(input logic [47:0] x);
    return {1'b1, x};
  endfunction
  function automatic logic [47:0] rnd48();
    return {16'($urandom), 32'($urandom)};
  endfunction
  task automatic drive(input logic [PB-1:0] leaf, input logic rdy, input logic [PB-1:0] net);
    @(negedge clk);
    i_leaf_data = leaf;
    i_net_ready = rdy;
    i_net_data  = net;
  endtask
  // reference model: the queue holds the packets that should be inside the buffer, in order
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      sb.delete();
      exp_count = 0;
      exp_ready = 1'b0;
      exp_ovf = 1'b0;
      exp_tx = '0;
      exp_rx = '0;
      exp_leaf_data = '0;
    end else begin
      bit mpop, mpush;
      mpop  = exp_count > 0 && i_net_ready;
      mpush = i_leaf_data[PB-1] && (exp_count < D || mpop);
      if (mpush) sb.push_back(i_leaf_data);
      if (i_leaf_data[PB-1] && !mpush) exp_ovf = 1'b1;
      exp_count = exp_count + int'(mpush) - int'(mpop);
      exp_ready = exp_count <= D - 2;
      exp_tx = exp_tx + CB'(mpop);
      exp_rx = exp_rx + CB'(i_net_data[PB-1]);
      exp_leaf_data = i_net_data;
    end
  end
  // handshake monitor: every packet taken by the switch must be the oldest expected one
  always @(posedge clk) begin
    if (reset && o_net_data[PB-1] && i_net_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected actual=%h required=none", o_net_data);
      end else begin
        chk("pop_order", 64'(o_net_data), 64'(sb.pop_front()));
      end
    end
  end
  // state monitor on the falling edge, away from the active edge
  always @(negedge clk) begin
    chk("occupancy", 64'(o_occupancy), 64'(exp_count));
    chk("leaf_ready", 64'(o_leaf_ready), 64'(exp_ready));
    chk("overflow", 64'(o_overflow), 64'(exp_ovf));
    chk("tx_count", 64'(o_tx_count), 64'(exp_tx));
    chk("rx_count", 64'(o_rx_count), 64'(exp_rx));
    chk("leaf_data", 64'(o_leaf_data), 64'(exp_leaf_data));
    chk("net_head", 64'(o_net_data), (exp_count > 0 && sb.size() > 0) ? 64'(sb[0]) : 64'(0));
  end
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(o_leaf_ready), 64'(0));
    reset = 1'b1;
    @(negedge clk);
    chk("ready_after_release", 64'(o_leaf_ready), 64'(1));
    drive(pkt(48'hAA), 1'b1, '0);
    drive(pkt(48'hBB), 1'b1, '0);
    repeat (3) drive('0, 1'b1, '0);
    chk("tp1_tx", 64'(o_tx_count), 64'(2));
    chk("tp1_occ", 64'(o_occupancy), 64'(0));
    for (int i = 1; i <= 7; i++) drive(pkt(48'(100 + i)), 1'b0, '0);
    drive(pkt(48'd108), 1'b0, '0);
    chk("tp2_occ7", 64'(o_occupancy), 64'(7));
    chk("tp2_ready0", 64'(o_leaf_ready), 64'(0));
    drive(pkt(48'd109), 1'b0, '0);
    drive('0, 1'b0, '0);
    chk("tp3_occ8", 64'(o_occupancy), 64'(8));
    drive('0, 1'b0, '0);
    chk("tp3_ovf", 64'(o_overflow), 64'(1));
    chk("tp3_head", 64'(o_net_data), 64'(pkt(48'd101)));
    for (int i = 0; i < 4; i++) drive(pkt(48'(200 + i)), 1'b1, '0);
    drive('0, 1'b0, '0);
    chk("tp4_occ8", 64'(o_occupancy), 64'(8));
    chk("tp4_head", 64'(o_net_data), 64'(pkt(48'd105)));
    repeat (12) drive('0, 1'b1, '0);
    chk("tp4_ovf_held", 64'(o_overflow), 64'(1));
    chk("tp4_drained", 64'(o_occupancy), 64'(0));
    drive('0, 1'b0, pkt(48'h123));
    drive('0, 1'b0, '0);
    chk("tp5_mirror", 64'(o_leaf_data), 64'(pkt(48'h123)));
    drive('0, 1'b0, pkt(48'h456));
    drive('0, 1'b0, '0);
    drive('0, 1'b0, '0);
    chk("tp5_rx", 64'(o_rx_count), 64'(2));
    for (int i = 0; i < 400; i++) begin
      logic [PB-1:0] leaf, net;
      leaf = ($urandom_range(2) != 0) ? pkt(rnd48()) : {1'b0, rnd48()};
      net  = $urandom_range(1) ? pkt(rnd48()) : {1'b0, rnd48()};
      drive(leaf, 1'($urandom_range(1)), net);
    end
    repeat (10) drive('0, 1'b1, '0);
    for (int i = 0; i < 5; i++) drive(pkt(48'(300 + i)), 1'b0, '0);
    drive('0, 1'b0, pkt(48'h77));
    @(negedge clk);
    chk("pre_rst_occ", 64'(o_occupancy), 64'(5));
    #2 reset = 1'b0;
    #1;
    chk("rst_occ", 64'(o_occupancy), 64'(0));
    chk("rst_net", 64'(o_net_data), 64'(0));
    chk("rst_leaf_data", 64'(o_leaf_data), 64'(0));
    chk("rst_ready", 64'(o_leaf_ready), 64'(0));
    chk("rst_tx", 64'(o_tx_count), 64'(0));
    chk("rst_rx", 64'(o_rx_count), 64'(0));
    chk("rst_ovf", 64'(o_overflow), 64'(0));
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rel_ready", 64'(o_leaf_ready), 64'(1));
    drive(pkt(48'hCC), 1'b1, '0);
    repeat (3) drive('0, 1'b1, '0);
    chk("post_rst_tx", 64'(o_tx_count), 64'(1));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
